// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   brt_state_e : resolve FSM encoding (RUN / RECOVER)
//   PC_INC      : fall-through pc increment used for not-taken redirects
package branch_resolve_unit_pkg;
  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} brt_state_e;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/brt_stage_reg.sv
// One branch-tracking pipeline stage: {valid, pred, pc, count}.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   load              advance: capture the *_d inputs
//   clear             drop the valid bit of whatever is being loaded
//   valid_d..count_d  incoming stage contents
//   valid..count      stage contents
module brt_stage_reg #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          clear,
  input  logic          valid_d,
  input  logic          pred_d,
  input  logic [31:0]   pc_d,
  input  logic [CW-1:0] count_d,
  output logic          valid,
  output logic          pred,
  output logic [31:0]   pc,
  output logic [CW-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pred  <= 1'b0;
      pc    <= '0;
      count <= '0;
    end else if (load) begin
      // payload still moves on a clear so pc/count stay meaningful indices
      valid <= valid_d && !clear;
      pred  <= pred_d;
      pc    <= pc_d;
      count <= count_d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolution side of the history predictor. Tracks IF predictions through
// ID and EX, compares with the real outcome in EX, drives train/rollback
// strobes, a registered flush/redirect and saturating perf counters.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   PL_stall_ex                       freezes ID/EX tracking, blocks resolution
//   br_valid_if, pred_taken_if,
//   pc_if, count_if                   IF-stage prediction
//   br_resolve_ex, actual_taken_ex,
//   actual_target_ex                  EX outcome
//   pc_id, pc_ex, count_ex            tracked stage contents
//   corrected_en, corrected_result    correct-prediction training strobe
//   rollback_en_ex, rollback_en_id    mispredict rollback strobes
//   flush_en, redirect_en, redirect_pc registered recovery outputs
//   busy                              FSM in RECOVER
//   branch_cnt, mispredict_cnt        saturating perf counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int JUMP_STATUS_COUNTER_WIDTH = 2,
  parameter int PERF_CNT_WIDTH            = 16,
  parameter int REFILL_CYCLES             = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 PL_stall_ex,
  input  logic                                 br_valid_if,
  input  logic                                 pred_taken_if,
  input  logic [31:0]                          pc_if,
  input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] count_if,
  input  logic                                 br_resolve_ex,
  input  logic                                 actual_taken_ex,
  input  logic [31:0]                          actual_target_ex,
  output logic [31:0]                          pc_id,
  output logic [31:0]                          pc_ex,
  output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] count_ex,
  output logic                                 corrected_en,
  output logic                                 corrected_result,
  output logic                                 rollback_en_ex,
  output logic                                 rollback_en_id,
  output logic                                 flush_en,
  output logic                                 redirect_en,
  output logic [31:0]                          redirect_pc,
  output logic                                 busy,
  output logic [PERF_CNT_WIDTH-1:0]            branch_cnt,
  output logic [PERF_CNT_WIDTH-1:0]            mispredict_cnt
);
  localparam int CW = JUMP_STATUS_COUNTER_WIDTH;
  localparam int RW = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);

  function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(
    input logic [PERF_CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  brt_state_e    state;
  logic [RW-1:0] refill_cnt;

  logic          id_valid, id_pred, ex_valid, ex_pred;
  logic [CW-1:0] id_count;
  logic          res, misp;

  assign busy = (state == RECOVER);
  assign res  = br_resolve_ex && ex_valid && !PL_stall_ex && (state == RUN);
  assign misp = res && (actual_taken_ex != ex_pred);

  assign corrected_en     = res && !misp;
  assign corrected_result = actual_taken_ex && corrected_en;
  assign rollback_en_ex   = misp;
  assign rollback_en_id   = misp && id_valid;

  // ID ignores new branches during recovery and on the mispredict edge itself
  brt_stage_reg #(.CW(CW)) u_id (
    .clk(clk), .rst_n(rst_n), .load(!PL_stall_ex), .clear(misp),
    .valid_d(br_valid_if && !busy), .pred_d(pred_taken_if),
    .pc_d(pc_if), .count_d(count_if),
    .valid(id_valid), .pred(id_pred), .pc(pc_id), .count(id_count)
  );

  brt_stage_reg #(.CW(CW)) u_ex (
    .clk(clk), .rst_n(rst_n), .load(!PL_stall_ex), .clear(misp),
    .valid_d(id_valid), .pred_d(id_pred), .pc_d(pc_id), .count_d(id_count),
    .valid(ex_valid), .pred(ex_pred), .pc(pc_ex), .count(count_ex)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      refill_cnt     <= '0;
      flush_en       <= 1'b0;
      redirect_en    <= 1'b0;
      redirect_pc    <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      flush_en       <= misp;
      redirect_en    <= misp;
      if (misp)
        redirect_pc <= actual_taken_ex ? actual_target_ex : pc_ex + PC_INC;
      branch_cnt     <= sat_inc(branch_cnt, res);
      mispredict_cnt <= sat_inc(mispredict_cnt, misp);
      unique case (state)
        RUN: begin
          if (misp) begin
            state      <= RECOVER;
            refill_cnt <= RW'(REFILL_CYCLES);
          end
        end
        RECOVER: begin
          // refill runs regardless of stall; leave on the cycle it reads 1
          if (refill_cnt <= RW'(1)) begin
            state      <= RUN;
            refill_cnt <= '0;
          end else begin
            refill_cnt <= refill_cnt - 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
